// File: rtl/alu_exec_stage_if.sv
// Handshake bundle between register-read, the execute-stage ALU and memory/writeback.
// The upstream/downstream side uses master and the ALU stage uses slave.
interface alu_exec_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             branch_taken;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, branch_taken, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, out_ready,
        output in_ready, out_valid, result, branch_taken, zero, illegal
    );
endinterface

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU: single-cycle logic/arith/branch ops, 1-bit-per-cycle serial shifter,
// valid/ready on both sides with a registered result held until downstream takes it.
module alu_exec_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_stage_if.slave   bus
);

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SLL  = 4'b0011;
    localparam logic [3:0] C_SLT  = 4'b0100;
    localparam logic [3:0] C_SRL  = 4'b0101;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_XOR  = 4'b1000;
    localparam logic [3:0] C_BNE  = 4'b1001;
    localparam logic [3:0] C_BEQ  = 4'b1010;
    localparam logic [3:0] C_BLT  = 4'b1011;
    localparam logic [3:0] C_BGE  = 4'b1100;
    localparam logic [3:0] C_PASS = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, state_nxt;
    logic                 in_ready_c;
    logic                 out_valid_c;
    logic                 accept;
    logic [SHAMT_W-1:0]   shamt;
    logic [SHAMT_W-1:0]   cnt_p1;
    logic [3:0]           sh_ctrl_p1;
    logic [WIDTH-1:0]     sh_p1;
    logic [WIDTH-1:0]     sh_next;
    logic [WIDTH-1:0]     result_p1;
    logic                 branch_p1;
    logic                 illegal_p1;
    logic                 start_shift;
    logic                 last_shift;

    function automatic logic is_shift(input logic [3:0] c);
        return (c == C_SLL) || (c == C_SRL) || (c == C_SRA);
    endfunction

    function automatic logic is_illegal(input logic [3:0] c);
        return (c == 4'b1110) || (c == 4'b1111);
    endfunction

    // Single-cycle result; shift codes only reach here with shamt == 0, so they pass op_a.
    function automatic logic [WIDTH-1:0] alu_result(input logic [3:0]       c,
                                                    input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (c)
            C_AND:                      return a & b;
            C_OR:                       return a | b;
            C_ADD:                      return a + b;
            C_SUB:                      return a - b;
            C_XOR:                      return a ^ b;
            C_SLT:                      return {{(WIDTH-1){1'b0}}, (sa < sb)};
            C_SLL, C_SRL, C_SRA:        return a;
            C_BNE, C_BEQ, C_BLT, C_BGE: return a - b;
            C_PASS:                     return b;
            default:                    return '0;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [3:0]       c,
                                         input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = signed'(a);
        sb = signed'(b);
        case (c)
            C_BNE:   return a != b;
            C_BEQ:   return a == b;
            C_BLT:   return sa < sb;
            C_BGE:   return sa >= sb;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       c,
                                                   input logic [WIDTH-1:0] v);
        case (c)
            C_SLL:   return {v[WIDTH-2:0], 1'b0};
            C_SRL:   return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign shamt       = bus.op_b[SHAMT_W-1:0];
    assign accept      = bus.in_valid && in_ready_c;
    assign start_shift = accept && is_shift(bus.alu_ctrl) && (shamt != '0);
    assign last_shift  = (state == SHIFT) && (cnt_p1 <= SHAMT_W'(1));
    assign sh_next     = shift_one(sh_ctrl_p1, sh_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = start_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (accept) begin
                    state_nxt = start_shift ? SHIFT : DONE;
                end else if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE:    in_ready_c = 1'b1;
            DONE: begin
                out_valid_c = 1'b1;
                in_ready_c  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Stage p1: shift counter (control, reset with the FSM)
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (start_shift) begin
            cnt_p1 <= shamt;
        end else if (state == SHIFT) begin
            cnt_p1 <= cnt_p1 - SHAMT_W'(1);
        end
    end

    // Stage p1: serial shifter working register, only meaningful while in SHIFT
    always_ff @(posedge clk) begin
        if (start_shift) begin
            sh_p1      <= bus.op_a;
            sh_ctrl_p1 <= bus.alu_ctrl;
        end else if (state == SHIFT) begin
            sh_p1      <= sh_next;
        end
    end

    // Stage p1: registered outputs; loaded only when an op completes, so they hold during stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            result_p1  <= '0;
            branch_p1  <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (accept && !start_shift) begin
            result_p1  <= alu_result(bus.alu_ctrl, bus.op_a, bus.op_b);
            branch_p1  <= branch_cond(bus.alu_ctrl, bus.op_a, bus.op_b);
            illegal_p1 <= is_illegal(bus.alu_ctrl);
        end else if (last_shift) begin
            result_p1  <= sh_next;
            branch_p1  <= 1'b0;
            illegal_p1 <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.result       = result_p1;
    assign bus.branch_taken = branch_p1;
    assign bus.illegal      = illegal_p1;
    assign bus.zero         = out_valid_c && (result_p1 == '0);

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: a behavioural model queues expected results at
// issue time; each test pops and compares them when out_valid is seen.
module tb_alu_exec_stage;

    typedef struct {
        logic [31:0] r;
        logic        br;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    alu_exec_stage_if #(.WIDTH(32)) bus ();

    alu_exec_stage #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.r   = 32'h0;
        e.br  = 1'b0;
        e.ill = 1'b0;
        case (c)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: e.r = a + b;
            4'b0110: e.r = a - b;
            4'b1000: e.r = a ^ b;
            4'b0100: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: e.r = a << b[4:0];
            4'b0101: e.r = a >> b[4:0];
            4'b0111: e.r = $signed(a) >>> b[4:0];
            4'b1001: begin e.r = a - b; e.br = (a != b); end
            4'b1010: begin e.r = a - b; e.br = (a == b); end
            4'b1011: begin e.r = a - b; e.br = ($signed(a) < $signed(b)); end
            4'b1100: begin e.r = a - b; e.br = ($signed(a) >= $signed(b)); end
            4'b1101: e.r = b;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Issues one op, pushes its expectation, and waits (bounded) for out_valid.
    // lat counts clock edges from the accepting edge; -1 means it never arrived.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy);
        int w;
        sb.push_back(model(c, a, b));
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = 4'h0;
        bus.op_a      = 32'h0;
        bus.op_b      = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.branch_taken, bus.zero, bus.illegal} !== 5'b01000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got ov/ir/br/z/ill=%b required 01000",
                     {bus.out_valid, bus.in_ready, bus.branch_taken, bus.zero, bus.illegal});
        end
        vectors++;
        if (bus.result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h required 00000000", bus.result);
        end
    endtask

    task automatic test_single_cycle();
        logic [3:0]  c[7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0100, 4'b0100, 4'b1000};
        logic [31:0] a[7] = '{32'h5, 32'h7, 32'hF0F0_1234, 32'h0F00_0000, 32'hFFFF_FFFE, 32'h3, 32'hAAAA_5555};
        logic [31:0] b[7] = '{32'hFFFF_FFFF, 32'h7, 32'h0FF0_FF00, 32'h0000_00F1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int i = 0; i < 7; i++) begin
            int   lat, busy;
            exp_t e;
            send(c[i], a[i], b[i], lat, busy);
            e = sb.pop_front();
            vectors++;
            if (lat !== 1) begin
                miscompares++;
                $display("FAIL arith_latency[%0d]: got %0d required 1", i, lat);
            end
            vectors++;
            if ({bus.result, bus.branch_taken, bus.zero, bus.illegal} !== {e.r, e.br, (e.r == 32'h0), e.ill}) begin
                miscompares++;
                $display("FAIL arith_out[%0d]: got r=%h br=%b z=%b ill=%b required r=%h br=%b z=%b ill=%b", i,
                         bus.result, bus.branch_taken, bus.zero, bus.illegal, e.r, e.br, (e.r == 32'h0), e.ill);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_shift();
        logic [3:0]  c[4]  = '{4'b0111, 4'b0101, 4'b0011, 4'b0011};
        logic [31:0] a[4]  = '{32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0000_0013};
        logic [31:0] b[4]  = '{32'h4, 32'h4, 32'h0, 32'h3};
        int          el[4] = '{5, 5, 1, 4};
        for (int i = 0; i < 4; i++) begin
            int   lat, busy;
            exp_t e;
            send(c[i], a[i], b[i], lat, busy);
            e = sb.pop_front();
            vectors++;
            if (lat !== el[i] || busy !== el[i] - 1) begin
                miscompares++;
                $display("FAIL shift_timing[%0d]: got lat=%0d busy=%0d required lat=%0d busy=%0d",
                         i, lat, busy, el[i], el[i] - 1);
            end
            vectors++;
            if ({bus.result, bus.branch_taken, bus.zero, bus.illegal} !== {e.r, e.br, (e.r == 32'h0), e.ill}) begin
                miscompares++;
                $display("FAIL shift_out[%0d]: got r=%h br=%b z=%b ill=%b required r=%h", i,
                         bus.result, bus.branch_taken, bus.zero, bus.illegal, e.r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [3:0]  c[5]  = '{4'b1011, 4'b1100, 4'b1010, 4'b1001, 4'b1001};
        logic [31:0] a[5]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h9, 32'h9, 32'h9};
        logic [31:0] b[5]  = '{32'h1, 32'h1, 32'h9, 32'h9, 32'h4};
        logic        eb[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            int   lat, busy;
            exp_t e;
            send(c[i], a[i], b[i], lat, busy);
            e = sb.pop_front();
            vectors++;
            if (bus.branch_taken !== eb[i] || lat !== 1) begin
                miscompares++;
                $display("FAIL branch_taken[%0d]: got %b lat=%0d required %b lat=1", i, bus.branch_taken, lat, eb[i]);
            end
            vectors++;
            if ({bus.result, bus.zero, bus.illegal} !== {e.r, (e.r == 32'h0), e.ill}) begin
                miscompares++;
                $display("FAIL branch_out[%0d]: got r=%h z=%b required r=%h z=%b", i,
                         bus.result, bus.zero, e.r, (e.r == 32'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        int   lat, busy;
        exp_t ex, ea;
        bus.out_ready = 1'b0;
        send(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000, lat, busy);
        ex = sb.pop_front();
        sb.push_back(model(4'b0010, 32'h0000_1000, 32'h0000_0234));
        bus.alu_ctrl = 4'b0010;
        bus.op_a     = 32'h0000_1000;
        bus.op_b     = 32'h0000_0234;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b0, ex.r}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got ov=%b ir=%b r=%h required ov=1 ir=0 r=%h",
                         i, bus.out_valid, bus.in_ready, bus.result, ex.r);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        ea = sb.pop_front();
        vectors++;
        if ({bus.out_valid, bus.result, bus.illegal} !== {1'b1, ea.r, ea.ill}) begin
            miscompares++;
            $display("FAIL stall_next_add: got ov=%b r=%h required ov=1 r=%h", bus.out_valid, bus.result, ea.r);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midshift();
        int stale;
        bus.alu_ctrl = 4'b0011;
        bus.op_a     = 32'h0000_0001;
        bus.op_b     = 32'd10;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b0, 1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL midshift_reset: got ov=%b ir=%b r=%h required ov=0 ir=1 r=00000000",
                     bus.out_valid, bus.in_ready, bus.result);
        end
        rst   = 1'b0;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        vectors++;
        if (stale !== 0) begin
            miscompares++;
            $display("FAIL midshift_stale: got %0d stale out_valid cycles required 0", stale);
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  c[3] = '{4'b1111, 4'b1101, 4'b1110};
        logic [31:0] b[3] = '{32'h5, 32'h1234_5000, 32'h7};
        for (int i = 0; i < 3; i++) begin
            int   lat, busy;
            exp_t e;
            send(c[i], 32'hFFFF_0001, b[i], lat, busy);
            e = sb.pop_front();
            vectors++;
            if ({bus.result, bus.branch_taken, bus.zero, bus.illegal} !== {e.r, e.br, (e.r == 32'h0), e.ill}
                || lat !== 1) begin
                miscompares++;
                $display("FAIL illegal_out[%0d]: got r=%h ill=%b z=%b lat=%0d required r=%h ill=%b z=%b lat=1", i,
                         bus.result, bus.illegal, bus.zero, lat, e.r, e.ill, (e.r == 32'h0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  c[4] = '{4'b0010, 4'b0110, 4'b1000, 4'b0001};
        logic [31:0] a[4] = '{32'h1, 32'h10, 32'hFF00_FF00, 32'h0};
        logic [31:0] b[4] = '{32'h2, 32'h20, 32'h0FF0_0FF0, 32'h8000_0000};
        exp_t        e;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({bus.out_valid, bus.in_ready, bus.result} !== {1'b1, 1'b1, e.r}) begin
                    miscompares++;
                    $display("FAIL b2b[%0d]: got ov=%b ir=%b r=%h required ov=1 ir=1 r=%h",
                             k - 1, bus.out_valid, bus.in_ready, bus.result, e.r);
                end
            end
            sb.push_back(model(c[k], a[k], b[k]));
            bus.alu_ctrl = c[k];
            bus.op_a     = a[k];
            bus.op_b     = b[k];
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({bus.out_valid, bus.result} !== {1'b1, e.r}) begin
            miscompares++;
            $display("FAIL b2b[3]: got ov=%b r=%h required ov=1 r=%h", bus.out_valid, bus.result, e.r);
        end
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_single_cycle();
        test_shift();
        test_branch();
        test_stall();
        test_reset_midshift();
        test_illegal();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
